// File: rtl/jk_ctrl.sv
// jk_ctrl: turns three raw push-buttons (set / clear / toggle) into single
// one-cycle J/K commands for a downstream JK flip-flop.
//
// Each button is synchronised (2 flops) and debounced. The controller
// accepts one command when a debounced level rises. It then locks out all
// buttons until every debounced level has returned low.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable cycles before a level is accepted (2..255)
// Ports
//   clk      : system clock, rising edge
//   n_rst    : asynchronous active-low reset
//   btn_set  : raw button, request q <= 1
//   btn_clr  : raw button, request q <= 0
//   btn_tog  : raw button, request q <= ~q
//   j, k     : registered JK drive, non-zero only in the ISSUE cycle
//   busy     : high while in ISSUE or LOCK
//   cmd_cnt  : number of commands issued since reset (wraps 255 -> 0)
module jk_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       btn_set,
  input  logic       btn_clr,
  input  logic       btn_tog,
  output logic       j,
  output logic       k,
  output logic       busy,
  output logic [7:0] cmd_cnt
);

  // Bit index of each button in the per-button vectors.
  localparam int unsigned B_SET = 0;
  localparam int unsigned B_CLR = 1;
  localparam int unsigned B_TOG = 2;

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  // Command codes are stored directly as {j,k}.
  localparam logic [1:0] JK_NONE = 2'b00;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_TOG  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    LOCK  = 2'd2
  } state_t;

  logic [2:0]      btn_s;
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0][7:0] cnt_q, cnt_d;
  logic [2:0]      deb_q, deb_d;
  state_t          state_q, state_d;
  logic [1:0]      cmd_q, cmd_d;
  logic            j_q, j_d;
  logic            k_q, k_d;
  logic            busy_q, busy_d;
  logic [7:0]      cmd_cnt_q, cmd_cnt_d;

  assign btn_s = {btn_tog, btn_clr, btn_set};

  // Debounce: count consecutive cycles where the synchronised level differs
  // from the accepted level; any agreeing cycle restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = 8'd0;
      end else if (cnt_q[i] == DEB_LAST) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = 8'd0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (deb_q != 3'b000) begin
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: state_d = LOCK;
      LOCK: begin
        if (deb_q == 3'b000) begin
          state_d = IDLE;
        end else begin
          state_d = LOCK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Command latch: only sampled in IDLE, clear beats set beats toggle.
  always_comb begin
    cmd_d = cmd_q;
    if (state_q == IDLE) begin
      if (deb_q[B_CLR]) begin
        cmd_d = JK_CLR;
      end else if (deb_q[B_SET]) begin
        cmd_d = JK_SET;
      end else if (deb_q[B_TOG]) begin
        cmd_d = JK_TOG;
      end else begin
        cmd_d = JK_NONE;
      end
    end else begin
      cmd_d = cmd_q;
    end
  end

  // Outputs are decoded from the next state, so the registered j/k/busy
  // line up exactly with the state register.
  always_comb begin
    j_d       = 1'b0;
    k_d       = 1'b0;
    busy_d    = (state_d != IDLE);
    cmd_cnt_d = cmd_cnt_q;
    if (state_d == ISSUE) begin
      j_d       = cmd_d[1];
      k_d       = cmd_d[0];
      cmd_cnt_d = cmd_cnt_q + 8'd1;
    end else begin
      j_d       = 1'b0;
      k_d       = 1'b0;
      cmd_cnt_d = cmd_cnt_q;
    end
  end

  // State, synchroniser, debounce and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q   <= 3'b000;
      sync2_q   <= 3'b000;
      cnt_q     <= '0;
      deb_q     <= 3'b000;
      state_q   <= IDLE;
      cmd_q     <= JK_NONE;
      j_q       <= 1'b0;
      k_q       <= 1'b0;
      busy_q    <= 1'b0;
      cmd_cnt_q <= 8'd0;
    end else begin
      sync1_q   <= btn_s;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      deb_q     <= deb_d;
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      j_q       <= j_d;
      k_q       <= k_d;
      busy_q    <= busy_d;
      cmd_cnt_q <= cmd_cnt_d;
    end
  end

  assign j       = j_q;
  assign k       = k_q;
  assign busy    = busy_q;
  assign cmd_cnt = cmd_cnt_q;

endmodule

// File: tb/tb_jk_ctrl.sv
// Directed testbench for jk_ctrl with DEBOUNCE_CYCLES = 4.
module tb_jk_ctrl;

  logic       clk;
  logic       n_rst;
  logic       btn_set, btn_clr, btn_tog;
  logic       j, k, busy;
  logic [7:0] cmd_cnt;

  int n_checks;
  int n_pass;
  int n_set_p, n_clr_p, n_tog_p;
  int lat;
  int exp_cnt;

  jk_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .btn_set (btn_set),
    .btn_clr (btn_clr),
    .btn_tog (btn_tog),
    .j       (j),
    .k       (k),
    .busy    (busy),
    .cmd_cnt (cmd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count the cycles spent on each J/K command code.
  always @(negedge clk) begin
    if (j && !k) n_set_p++;
    if (!j && k) n_clr_p++;
    if (j && k)  n_tog_p++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Wait (bounded) for j or k to go high; returns negedges waited, -1 on timeout.
  task automatic wait_pulse(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (j || k) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    n_set_p = 0; n_clr_p = 0; n_tog_p = 0;
    exp_cnt = 0;
    n_rst = 1'b0;
    btn_set = 1'b0; btn_clr = 1'b0; btn_tog = 1'b0;
    wait_cyc(3);
    chk("rst_j", 32'(j), 32'd0);
    chk("rst_k", 32'(k), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(cmd_cnt), 32'd0);
    n_rst = 1'b1;
    wait_cyc(2);

    // Held set: one J-only pulse 7 cycles after the press.
    btn_set = 1'b1;
    wait_pulse(lat);
    exp_cnt++;
    chk("set_lat", 32'(lat), 32'd7);
    chk("set_jk", 32'({j, k}), 32'd2);
    chk("set_busy", 32'(busy), 32'd1);
    chk("set_cnt", 32'(cmd_cnt), 32'(exp_cnt));
    wait_cyc(13);
    chk("set_hold_busy", 32'(busy), 32'd1);
    chk("set_hold_jk", 32'({j, k}), 32'd0);
    btn_set = 1'b0;
    wait_cyc(12);
    chk("set_rel_busy", 32'(busy), 32'd0);
    chk("set_npulse", 32'(n_set_p), 32'd1);

    // Short glitches (2 and 3 cycles) must be filtered.
    btn_tog = 1'b1; wait_cyc(2); btn_tog = 1'b0; wait_cyc(15);
    btn_tog = 1'b1; wait_cyc(3); btn_tog = 1'b0; wait_cyc(15);
    chk("glitch_tog", 32'(n_tog_p), 32'd0);
    chk("glitch_cnt", 32'(cmd_cnt), 32'(exp_cnt));
    chk("glitch_busy", 32'(busy), 32'd0);

    // Exactly DEBOUNCE_CYCLES is accepted: toggle issues j=k=1.
    btn_tog = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk); @(negedge clk);
    btn_tog = 1'b0;
    exp_cnt++;
    wait_pulse(lat);
    chk("tog4_lat", 32'(lat + 4), 32'd7);
    chk("tog4_jk", 32'({j, k}), 32'd3);
    wait_cyc(12);
    chk("tog4_npulse", 32'(n_tog_p), 32'd1);
    chk("tog4_cnt", 32'(cmd_cnt), 32'(exp_cnt));

    // Set and clear together: clear wins.
    btn_set = 1'b1; btn_clr = 1'b1;
    wait_pulse(lat);
    exp_cnt++;
    chk("prio_jk", 32'({j, k}), 32'd1);
    wait_cyc(4);
    btn_set = 1'b0; btn_clr = 1'b0;
    wait_cyc(12);
    chk("prio_nclr", 32'(n_clr_p), 32'd1);
    chk("prio_nset", 32'(n_set_p), 32'd1);
    chk("prio_cnt", 32'(cmd_cnt), 32'(exp_cnt));

    // Toggle pressed during LOCK is ignored and not queued.
    btn_set = 1'b1;
    wait_pulse(lat);
    exp_cnt++;
    chk("lock_jk", 32'({j, k}), 32'd2);
    wait_cyc(3);
    btn_tog = 1'b1;
    wait_cyc(10);
    chk("lock_busy", 32'(busy), 32'd1);
    btn_set = 1'b0; btn_tog = 1'b0;
    wait_cyc(15);
    chk("lock_ntog", 32'(n_tog_p), 32'd1);
    chk("lock_nset", 32'(n_set_p), 32'd2);
    chk("lock_cnt", 32'(cmd_cnt), 32'(exp_cnt));

    // 256 clear commands wrap the counter back to its start value.
    for (int i = 0; i < 256; i++) begin
      btn_clr = 1'b1;
      wait_cyc(8);
      btn_clr = 1'b0;
      wait_cyc(10);
    end
    chk("wrap_nclr", 32'(n_clr_p), 32'd257);
    chk("wrap_cnt", 32'(cmd_cnt), 32'(exp_cnt));
    chk("wrap_busy", 32'(busy), 32'd0);

    // Reset in the ISSUE cycle clears everything immediately.
    btn_set = 1'b1;
    wait_pulse(lat);
    chk("rstiss_pre_jk", 32'({j, k}), 32'd2);
    n_rst = 1'b0;
    #1;
    chk("rstiss_jk", 32'({j, k}), 32'd0);
    chk("rstiss_busy", 32'(busy), 32'd0);
    chk("rstiss_cnt", 32'(cmd_cnt), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    // Button still held: debounced from scratch, then one command.
    wait_pulse(lat);
    chk("rel_lat", 32'(lat), 32'd7);
    chk("rel_jk", 32'({j, k}), 32'd2);
    chk("rel_cnt", 32'(cmd_cnt), 32'd1);
    btn_set = 1'b0;
    wait_cyc(12);
    chk("rel_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
